// File: rtl/adc_responder_pkg.sv
// Shared constants for the serial ADC responder: sample/frame geometry,
// FSM encodings and a saturating counter helper.
package adc_responder_pkg;

  localparam int ADC_WIDTH      = 12;
  localparam int ADC_CLK_DIV    = 4;
  localparam int ADC_LEAD_BITS  = 3;
  localparam int ADC_FRAME_BITS = ADC_LEAD_BITS + ADC_WIDTH;

  localparam logic [1:0] ADCR_IDLE  = 2'd0;
  localparam logic [1:0] ADCR_SHIFT = 2'd1;
  localparam logic [1:0] ADCR_DONE  = 2'd2;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/adc_responder_sync_edge.sv
// Synchronizer for an asynchronous pin plus rise/fall pulse detection.
// Edges are masked until the chain and history flop hold real pin samples.
module adc_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [SYNC_STAGES:0]   primed_q;
  logic                   level_s;

  assign level_s = sync_q[SYNC_STAGES-1];

  // Synchronizer chain, edge history and post-reset priming shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= {SYNC_STAGES{RESET_LEVEL}};
      prev_q   <= RESET_LEVEL;
      primed_q <= '0;
    end else begin
      sync_q   <= (sync_q << 1) | SYNC_STAGES'(d_i);
      prev_q   <= level_s;
      primed_q <= {primed_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // A pin already away from its idle level at reset release is not an edge
  assign rise_o = primed_q[SYNC_STAGES] &  level_s & ~prev_q;
  assign fall_o = primed_q[SYNC_STAGES] & ~level_s &  prev_q;

endmodule

// File: rtl/adc_responder.sv
// Device side of the serial ADC link: shifts 12-bit stream samples out MSB
// first behind LEAD_BITS zeros, driven by the reader's adc_clk / adc_cs.
module adc_responder #(
  parameter int ADC_WIDTH   = adc_responder_pkg::ADC_WIDTH,
  parameter int LEAD_BITS   = adc_responder_pkg::ADC_LEAD_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 adc_clk,
  input  logic                 adc_cs,
  output logic                 adc_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [ADC_WIDTH-1:0] s_value,
  output logic                 frame_done,
  output logic                 frame_abort,
  output logic [7:0]           underrun_cnt
);
  import adc_responder_pkg::*;

  localparam int                FRAME_BITS = LEAD_BITS + ADC_WIDTH;
  localparam int                CNT_W      = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(FRAME_BITS - 1);

  logic clk_fall_s, clk_rise_unused_s, cs_fall_s, cs_rise_s;

  logic [1:0]            state_q, state_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  data_q, data_d;
  logic                  done_q, done_d;
  logic                  abort_q, abort_d;
  logic [ADC_WIDTH-1:0]  hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [ADC_WIDTH-1:0]  last_q, last_d;
  logic [7:0]            under_q, under_d;
  logic [ADC_WIDTH-1:0]  sample_s;

  adc_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_clk_sync (
    .clk(clk), .rst_n(rst_n), .d_i(adc_clk), .rise_o(clk_rise_unused_s), .fall_o(clk_fall_s)
  );

  adc_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b1)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .d_i(adc_cs), .rise_o(cs_rise_s), .fall_o(cs_fall_s)
  );

  assign s_ready      = ~hold_full_q;
  assign adc_data     = data_q;
  assign frame_done   = done_q;
  assign frame_abort  = abort_q;
  assign underrun_cnt = under_q;

  // Next-state logic: sample hand-off, frame load and bit shifting
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    data_d      = data_q;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    last_d      = last_q;
    under_d     = under_q;
    sample_s    = last_q;

    if (s_valid && s_ready) begin
      hold_d      = s_value;
      hold_full_d = 1'b1;
    end else begin
      hold_d      = hold_q;
    end

    // A cs fall restarts the frame from any state, including a glitch mid-frame
    if (cs_fall_s) begin
      if (hold_full_q) begin
        sample_s    = hold_q;
        hold_full_d = 1'b0;
      end else if (s_valid) begin
        sample_s    = s_value;
        hold_d      = hold_q;
        hold_full_d = 1'b0;
      end else begin
        sample_s    = last_q;
        under_d     = sat_inc8(under_q);
      end
      last_d    = sample_s;
      shreg_d   = FRAME_BITS'(sample_s);
      bit_cnt_d = '0;
      data_d    = shreg_d[FRAME_BITS-1];
      state_d   = ADCR_SHIFT;
    end else begin
      case (state_q)
        ADCR_IDLE: begin
          data_d = 1'b0;
        end
        ADCR_SHIFT: begin
          if (cs_rise_s) begin
            data_d  = 1'b0;
            abort_d = 1'b1;
            state_d = ADCR_IDLE;
          end else if (clk_fall_s) begin
            if (bit_cnt_q == LAST_BIT) begin
              data_d  = 1'b0;
              done_d  = 1'b1;
              state_d = ADCR_DONE;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
              shreg_d   = {shreg_q[FRAME_BITS-2:0], 1'b0};
              data_d    = shreg_q[FRAME_BITS-2];
            end
          end else begin
            state_d = state_q;
          end
        end
        ADCR_DONE: begin
          data_d = 1'b0;
          if (cs_rise_s) begin
            state_d = ADCR_IDLE;
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          data_d  = 1'b0;
          state_d = ADCR_IDLE;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ADCR_IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      data_q      <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      last_q      <= '0;
      under_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      data_q      <= data_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      last_q      <= last_d;
      under_q     <= under_d;
    end
  end

endmodule

// File: tb/tb_adc_responder.sv
// Directed bench for adc_responder: acts as the ADC reader, capturing adc_data
// on each rising adc_clk and checking frames against hand-computed bit patterns.
module tb_adc_responder;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst_n, adc_clk, adc_cs, adc_data;
  logic        s_valid, s_ready, frame_done, frame_abort;
  logic [11:0] s_value;
  logic [7:0]  underrun_cnt;

  int compared = 0;
  int mismatched = 0;
  int done_seen = 0;
  int abort_seen = 0;

  adc_responder dut (
    .clk(clk), .rst_n(rst_n), .adc_clk(adc_clk), .adc_cs(adc_cs), .adc_data(adc_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_value(s_value),
    .frame_done(frame_done), .frame_abort(frame_abort), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (frame_done) done_seen++;
    if (frame_abort) abort_seen++;
  endtask

  task automatic push(input logic [11:0] v);
    int n;
    n = 0;
    while (!s_ready && n < 50) begin tick(); n++; end
    compared++;
    if (s_ready !== 1'b1) begin mismatched++; $display("FAIL push_ready: got %b want 1", s_ready); end
    s_valid = 1'b1; s_value = v;
    tick();
    s_valid = 1'b0;
  endtask

  // Reader side of one frame; with cs_low_already the caller has already spent 3 cycles after cs fell
  task automatic run_frame(input bit cs_low_already, output logic [14:0] bits);
    bits = '0;
    if (!cs_low_already) begin
      adc_cs = 1'b0;
      repeat (HALF) tick();
    end else begin
      repeat (HALF - 3) tick();
    end
    for (int k = 0; k < 15; k++) begin
      adc_clk = 1'b1;
      bits[14-k] = adc_data;
      repeat (HALF) tick();
      adc_clk = 1'b0;
      repeat (HALF) tick();
    end
    adc_cs = 1'b1;
    repeat (HALF) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; adc_clk = 1'b0; adc_cs = 1'b1; s_valid = 1'b0; s_value = 12'h000;
    repeat (3) @(posedge clk);
    #1;
    compared++; if (adc_data !== 1'b0) begin mismatched++; $display("FAIL reset_data: got %b want 0", adc_data); end
    compared++; if (s_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %b want 1", s_ready); end
    compared++; if (frame_done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b want 0", frame_done); end
    compared++; if (frame_abort !== 1'b0) begin mismatched++; $display("FAIL reset_abort: got %b want 0", frame_abort); end
    compared++; if (underrun_cnt !== 8'd0) begin mismatched++; $display("FAIL reset_underrun: got %0d want 0", underrun_cnt); end
    rst_n = 1'b1;
    repeat (5) tick();
  endtask

  task automatic test_loopback();
    logic [14:0] bits;
    done_seen = 0; abort_seen = 0;
    push(12'hA5C);
    compared++; if (s_ready !== 1'b0) begin mismatched++; $display("FAIL loop_hold_full: got %b want 0", s_ready); end
    run_frame(1'b0, bits);
    compared++; if (bits !== 15'b000101001011100) begin mismatched++; $display("FAIL loop_bits: got %b want 000101001011100", bits); end
    compared++; if (done_seen !== 1) begin mismatched++; $display("FAIL loop_done: got %0d pulses want 1", done_seen); end
    compared++; if (abort_seen !== 0) begin mismatched++; $display("FAIL loop_abort: got %0d pulses want 0", abort_seen); end
    compared++; if (underrun_cnt !== 8'd0) begin mismatched++; $display("FAIL loop_underrun: got %0d want 0", underrun_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [14:0] bits;
    push(12'h123);
    s_valid = 1'b1; s_value = 12'h456;
    repeat (2) tick();
    compared++; if (s_ready !== 1'b0) begin mismatched++; $display("FAIL b2b_stall: got %b want 0", s_ready); end
    run_frame(1'b0, bits);
    s_valid = 1'b0;
    compared++; if (bits !== {3'b000, 12'h123}) begin mismatched++; $display("FAIL b2b_frame1: got %h want %h", bits, {3'b000, 12'h123}); end
    compared++; if (s_ready !== 1'b0) begin mismatched++; $display("FAIL b2b_second_held: got %b want 0", s_ready); end
    run_frame(1'b0, bits);
    compared++; if (bits !== {3'b000, 12'h456}) begin mismatched++; $display("FAIL b2b_frame2: got %h want %h", bits, {3'b000, 12'h456}); end
    compared++; if (s_ready !== 1'b1) begin mismatched++; $display("FAIL b2b_ready_after: got %b want 1", s_ready); end
    compared++; if (underrun_cnt !== 8'd0) begin mismatched++; $display("FAIL b2b_underrun: got %0d want 0", underrun_cnt); end
  endtask

  task automatic test_underrun();
    logic [14:0] bits;
    push(12'h7FF);
    for (int f = 0; f < 3; f++) begin
      run_frame(1'b0, bits);
      compared++; if (bits !== {3'b000, 12'h7FF}) begin mismatched++; $display("FAIL underrun_frame%0d: got %h want %h", f, bits, {3'b000, 12'h7FF}); end
    end
    compared++; if (underrun_cnt !== 8'd2) begin mismatched++; $display("FAIL underrun_cnt: got %0d want 2", underrun_cnt); end
  endtask

  task automatic test_abort();
    logic [14:0] bits;
    done_seen = 0; abort_seen = 0;
    push(12'h3C5);
    adc_cs = 1'b0;
    repeat (HALF) tick();
    for (int k = 0; k < 6; k++) begin
      adc_clk = 1'b1; repeat (HALF) tick();
      adc_clk = 1'b0; repeat (HALF) tick();
    end
    // frame bit 6 is sample bit 8 of 0x3C5
    compared++; if (adc_data !== 1'b1) begin mismatched++; $display("FAIL abort_bit6: got %b want 1", adc_data); end
    adc_cs = 1'b1;
    repeat (3) tick();
    compared++; if (abort_seen !== 1) begin mismatched++; $display("FAIL abort_pulse: got %0d pulses want 1", abort_seen); end
    compared++; if (adc_data !== 1'b0) begin mismatched++; $display("FAIL abort_data: got %b want 0", adc_data); end
    compared++; if (done_seen !== 0) begin mismatched++; $display("FAIL abort_no_done: got %0d pulses want 0", done_seen); end
    repeat (HALF) tick();
    run_frame(1'b0, bits);
    compared++; if (bits !== {3'b000, 12'h3C5}) begin mismatched++; $display("FAIL abort_next_frame: got %h want %h", bits, {3'b000, 12'h3C5}); end
    compared++; if (underrun_cnt !== 8'd3) begin mismatched++; $display("FAIL abort_underrun: got %0d want 3", underrun_cnt); end
  endtask

  task automatic test_bypass();
    logic [14:0] bits;
    adc_cs = 1'b0;
    repeat (2) tick();
    s_valid = 1'b1; s_value = 12'h0F0;
    tick();
    s_valid = 1'b0;
    compared++; if (s_ready !== 1'b1) begin mismatched++; $display("FAIL bypass_hold_empty: got %b want 1", s_ready); end
    run_frame(1'b1, bits);
    compared++; if (bits !== {3'b000, 12'h0F0}) begin mismatched++; $display("FAIL bypass_frame: got %h want %h", bits, {3'b000, 12'h0F0}); end
    compared++; if (underrun_cnt !== 8'd3) begin mismatched++; $display("FAIL bypass_underrun: got %0d want 3", underrun_cnt); end
    run_frame(1'b0, bits);
    compared++; if (bits !== {3'b000, 12'h0F0}) begin mismatched++; $display("FAIL bypass_repeat: got %h want %h", bits, {3'b000, 12'h0F0}); end
    compared++; if (underrun_cnt !== 8'd4) begin mismatched++; $display("FAIL bypass_repeat_underrun: got %0d want 4", underrun_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    logic [14:0] bits;
    push(12'h222);
    adc_cs = 1'b0;
    repeat (HALF) tick();
    push(12'h333);
    for (int k = 0; k < 4; k++) begin
      adc_clk = 1'b1; repeat (HALF) tick();
      adc_clk = 1'b0; repeat (HALF) tick();
    end
    rst_n = 1'b0;
    #1;
    compared++; if (adc_data !== 1'b0) begin mismatched++; $display("FAIL rstmid_data: got %b want 0", adc_data); end
    compared++; if (s_ready !== 1'b1) begin mismatched++; $display("FAIL rstmid_ready: got %b want 1", s_ready); end
    compared++; if (frame_done !== 1'b0) begin mismatched++; $display("FAIL rstmid_done: got %b want 0", frame_done); end
    compared++; if (frame_abort !== 1'b0) begin mismatched++; $display("FAIL rstmid_abort: got %b want 0", frame_abort); end
    compared++; if (underrun_cnt !== 8'd0) begin mismatched++; $display("FAIL rstmid_underrun: got %0d want 0", underrun_cnt); end
    tick();
    rst_n = 1'b1;
    done_seen = 0; abort_seen = 0;
    // cs still low after release: no frame may start
    for (int k = 0; k < 2; k++) begin
      adc_clk = 1'b1; repeat (HALF) tick();
      compared++; if (adc_data !== 1'b0) begin mismatched++; $display("FAIL rstmid_idle_data%0d: got %b want 0", k, adc_data); end
      adc_clk = 1'b0; repeat (HALF) tick();
    end
    compared++; if (done_seen !== 0 || abort_seen !== 0) begin mismatched++; $display("FAIL rstmid_no_pulses: got done %0d abort %0d want 0 0", done_seen, abort_seen); end
    adc_cs = 1'b1;
    repeat (HALF) tick();
    run_frame(1'b0, bits);
    compared++; if (bits !== 15'h0000) begin mismatched++; $display("FAIL rstmid_hold_lost: got %h want 0000", bits); end
    compared++; if (underrun_cnt !== 8'd1) begin mismatched++; $display("FAIL rstmid_underrun_after: got %0d want 1", underrun_cnt); end
    push(12'h6B9);
    run_frame(1'b0, bits);
    compared++; if (bits !== {3'b000, 12'h6B9}) begin mismatched++; $display("FAIL rstmid_resume: got %h want %h", bits, {3'b000, 12'h6B9}); end
    compared++; if (underrun_cnt !== 8'd1) begin mismatched++; $display("FAIL rstmid_resume_underrun: got %0d want 1", underrun_cnt); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_bypass();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
